data_mem_bank: RTL and testbench

DATA_MEM_BANK -- requirements
Module: data_mem_bank

---
 rtl/codes_pkg.sv | 13 +
 rtl/load_align.sv | 24 ++
 rtl/data_mem_bank.sv | 146 ++++++++++++++
 tb/tb_data_mem_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/codes_pkg.sv
// Shared widths and access-size encodings for the data memory bank and its helpers.
package codes_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 256;
    localparam int WORD_WIDTH = DATA_WIDTH;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_align import codes_pkg::*; #(
    parameter int DATA_WIDTH = codes_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]           word,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    input  mem_size_t                       size,
    input  logic                            load_unsigned,
    output logic [DATA_WIDTH-1:0]           data
);
    logic [15:0] low_half;

    always_comb begin
        low_half = 16'(word >> {offset, 3'b000});
        data     = word;
        case (size)
            MEM_BYTE: data = load_unsigned ? {{(DATA_WIDTH-8){1'b0}}, low_half[7:0]}
                                           : {{(DATA_WIDTH-8){low_half[7]}}, low_half[7:0]};
            MEM_HALF: data = load_unsigned ? {{(DATA_WIDTH-16){1'b0}}, low_half}
                                           : {{(DATA_WIDTH-16){low_half[15]}}, low_half};
            default:  data = word;
        endcase
    end
endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressable data memory with sized/extended loads, per-byte stores,
// alignment checking and a 1- or 2-stage read pipeline.
module data_mem_bank import codes_pkg::*; #(
    parameter int DATA_WIDTH   = codes_pkg::DATA_WIDTH,
    parameter int DEPTH        = codes_pkg::DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  mem_size_t             mem_size,
    input  logic                  mem_unsigned,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    output logic                  misaligned
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int IDXW   = $clog2(DEPTH);

    logic [OFFW-1:0]       offset;
    logic [IDXW-1:0]       idx;
    logic                  bad_access;
    logic                  wr_en;
    logic                  rd_en;
    logic [NBYTES-1:0]     byte_en;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  unused_addr_bits;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  misaligned_q, misaligned_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_word_q, s1_word_d;
    logic [OFFW-1:0]       s1_offset_q, s1_offset_d;
    mem_size_t             s1_size_q, s1_size_d;
    logic                  s1_unsigned_q, s1_unsigned_d;
    logic [DATA_WIDTH-1:0] s1_data;

    // Address bits above the word index are deliberately dropped so indices wrap.
    assign unused_addr_bits = ^addr[DATA_WIDTH-1:OFFW+IDXW];

    always_comb begin
        offset = addr[OFFW-1:0];
        idx    = addr[OFFW +: IDXW];
        case (mem_size)
            MEM_BYTE: bad_access = 1'b0;
            MEM_HALF: bad_access = offset[0];
            MEM_WORD: bad_access = (offset != '0);
            default:  bad_access = 1'b1;
        endcase
        wr_en = mem_write && !bad_access && !rst;
        rd_en = mem_read && !mem_write && !bad_access;
        case (mem_size)
            MEM_BYTE: byte_en = {{(NBYTES-1){1'b0}}, 1'b1} << offset;
            MEM_HALF: byte_en = {{(NBYTES-2){1'b0}}, 2'b11} << offset;
            MEM_WORD: byte_en = '1;
            default:  byte_en = '0;
        endcase
        wr_word      = write_data << {offset, 3'b000};
        misaligned_d = (mem_read || mem_write) && bad_access;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    // Load metadata is held between loads so the aligned result stays stable.
    always_comb begin
        s1_valid_d    = rd_en;
        s1_word_d     = s1_word_q;
        s1_offset_d   = s1_offset_q;
        s1_size_d     = s1_size_q;
        s1_unsigned_d = s1_unsigned_q;
        if (rd_en) begin
            s1_word_d     = mem_q[idx];
            s1_offset_d   = offset;
            s1_size_d     = mem_size;
            s1_unsigned_d = mem_unsigned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q  <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_word_q     <= '0;
            s1_offset_q   <= '0;
            s1_size_q     <= MEM_BYTE;
            s1_unsigned_q <= 1'b0;
        end else begin
            misaligned_q  <= misaligned_d;
            s1_valid_q    <= s1_valid_d;
            s1_word_q     <= s1_word_d;
            s1_offset_q   <= s1_offset_d;
            s1_size_q     <= s1_size_d;
            s1_unsigned_q <= s1_unsigned_d;
        end
    end

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .word          (s1_word_q),
        .offset        (s1_offset_q),
        .size          (s1_size_q),
        .load_unsigned (s1_unsigned_q),
        .data          (s1_data)
    );

    assign misaligned = misaligned_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid_q, s2_valid_d;
            logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

            // Result is captured here, so later stores cannot disturb it.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data : s2_data_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign read_data = s2_data_q;
            assign rd_valid  = s2_valid_q;
        end else begin : g_lat1
            assign read_data = s1_data;
            assign rd_valid  = s1_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_bank.sv
// Drives a latency-1 and a latency-2 bank with identical stimulus and checks both
// every cycle against a byte-array model, plus hand-computed directed results.
module tb_data_mem_bank;
   import codes_pkg::*;

   localparam int TB_DEPTH   = 16;
   localparam int BYTE_SPACE = TB_DEPTH * 4;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        mem_unsigned = 1'b0;
   mem_size_t   mem_size = MEM_WORD;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;

   logic [31:0] rd1, rd2;
   logic        rv1, rv2, mis1, mis2;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [7:0]  mm [BYTE_SPACE];
   exp_t        q1[$];
   exp_t        q2[$];
   int          mis_q[$];
   logic [31:0] last1 = '0;
   logic [31:0] last2 = '0;

   data_mem_bank #(.DATA_WIDTH(32), .DEPTH(TB_DEPTH), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
      .write_data(write_data), .read_data(rd1), .rd_valid(rv1), .misaligned(mis1)
   );

   data_mem_bank #(.DATA_WIDTH(32), .DEPTH(TB_DEPTH), .READ_LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
      .write_data(write_data), .read_data(rd2), .rd_valid(rv2), .misaligned(mis2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic is_bad(input mem_size_t sz, input logic [31:0] a);
      case (sz)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return a[0];
         MEM_WORD: return a[1:0] != 2'b00;
         default:  return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a_in, input mem_size_t sz, input logic uns);
      int a;
      a = int'(a_in % BYTE_SPACE);
      case (sz)
         MEM_BYTE: return uns ? {24'b0, mm[a]} : {{24{mm[a][7]}}, mm[a]};
         MEM_HALF: return uns ? {16'b0, mm[a+1], mm[a]} : {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
         default:  return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
      endcase
   endfunction

   function automatic void model_store(input logic [31:0] a_in, input mem_size_t sz, input logic [31:0] wd);
      int a;
      int n;
      a = int'(a_in % BYTE_SPACE);
      n = (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF) ? 2 : 4;
      for (int k = 0; k < n; k++) mm[a+k] = wd[8*k +: 8];
   endfunction

   // Reference model: consumes each accepted request at the clock edge and
   // schedules the outputs each bank must show once its latency has elapsed.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst && (mem_read || mem_write)) begin
         if (is_bad(mem_size, addr)) mis_q.push_back(cyc);
         else if (mem_write) model_store(addr, mem_size, write_data);
         else begin
            q1.push_back('{cyc, model_load(addr, mem_size, mem_unsigned)});
            q2.push_back('{cyc + 1, model_load(addr, mem_size, mem_unsigned)});
         end
      end
   end

   // Per-cycle comparison on the falling edge, away from the register updates.
   always @(negedge clk) begin : compare
      logic em, ev1, ev2;
      if (rst) begin
         q1.delete(); q2.delete(); mis_q.delete();
         last1 = '0; last2 = '0;
         checkOutput("rst_valid_l1", {31'b0, rv1}, 0);
         checkOutput("rst_valid_l2", {31'b0, rv2}, 0);
         checkOutput("rst_data_l1", rd1, 0);
         checkOutput("rst_data_l2", rd2, 0);
         checkOutput("rst_mis_l1", {31'b0, mis1}, 0);
         checkOutput("rst_mis_l2", {31'b0, mis2}, 0);
      end else begin
         em = 1'b0; ev1 = 1'b0; ev2 = 1'b0;
         if (mis_q.size() > 0 && mis_q[0] == cyc) begin em = 1'b1; void'(mis_q.pop_front()); end
         if (q1.size() > 0 && q1[0].due == cyc) begin ev1 = 1'b1; last1 = q1[0].data; void'(q1.pop_front()); end
         if (q2.size() > 0 && q2[0].due == cyc) begin ev2 = 1'b1; last2 = q2[0].data; void'(q2.pop_front()); end
         checkOutput("cyc_valid_l1", {31'b0, rv1}, {31'b0, ev1});
         checkOutput("cyc_valid_l2", {31'b0, rv2}, {31'b0, ev2});
         checkOutput("cyc_data_l1", rd1, last1);
         checkOutput("cyc_data_l2", rd2, last2);
         checkOutput("cyc_mis_l1", {31'b0, mis1}, {31'b0, em});
         checkOutput("cyc_mis_l2", {31'b0, mis2}, {31'b0, em});
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic idle();
      mem_read = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input mem_size_t sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd);
      mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      addr = a; write_data = wd;
      tick();
   endtask

   // Issues one load and pins the literal result on both banks at their exact latency.
   task automatic expectLoad(input string name, input logic [31:0] a, input mem_size_t sz,
                             input logic uns, input logic [31:0] lit);
      checkOutput({name, "_model"}, model_load(a, sz, uns), lit);
      applyStimulus(1'b1, 1'b0, sz, uns, a, '0);
      idle();
      checkOutput({name, "_l1_valid"}, {31'b0, rv1}, 1);
      checkOutput({name, "_l1_data"}, rd1, lit);
      checkOutput({name, "_l2_early"}, {31'b0, rv2}, 0);
      tick();
      checkOutput({name, "_l1_pulse"}, {31'b0, rv1}, 0);
      checkOutput({name, "_l2_valid"}, {31'b0, rv2}, 1);
      checkOutput({name, "_l2_data"}, rd2, lit);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] ra;
      int          sel;
      mem_size_t   rs;

      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < TB_DEPTH; i++) applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'(i * 4), '0);
      idle();
      tick();

      $display("[TB] word store/load");
      applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0, 32'hDEADBEEF);
      expectLoad("word_rt", 32'h0, MEM_WORD, 1'b0, 32'hDEADBEEF);

      $display("[TB] byte store and extension");
      applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h3, 32'h80);
      expectLoad("byte_signed", 32'h3, MEM_BYTE, 1'b0, 32'hFFFFFF80);
      expectLoad("byte_unsigned", 32'h3, MEM_BYTE, 1'b1, 32'h00000080);
      expectLoad("byte_word", 32'h0, MEM_WORD, 1'b0, 32'h80000000);

      $display("[TB] misaligned accesses");
      applyStimulus(1'b1, 1'b0, MEM_HALF, 1'b0, 32'h1, '0);
      idle();
      checkOutput("mis_half_l1", {31'b0, mis1}, 1);
      checkOutput("mis_half_l2", {31'b0, mis2}, 1);
      checkOutput("mis_half_novalid", {31'b0, rv1}, 0);
      tick();
      checkOutput("mis_half_pulse", {31'b0, mis1}, 0);
      checkOutput("mis_half_novalid_l2", {31'b0, rv2}, 0);
      applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h2, 32'h12345678);
      idle();
      checkOutput("mis_word_store", {31'b0, mis1}, 1);
      tick();
      expectLoad("mis_unchanged", 32'h0, MEM_WORD, 1'b0, 32'h80000000);

      $display("[TB] wrap and read/write collision");
      applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'(TB_DEPTH * 4), 32'hCAFEF00D);
      expectLoad("wrap", 32'h0, MEM_WORD, 1'b0, 32'hCAFEF00D);
      applyStimulus(1'b1, 1'b1, MEM_WORD, 1'b0, 32'h4, 32'hA5A5A5A5);
      idle();
      checkOutput("collide_l1", {31'b0, rv1}, 0);
      tick();
      checkOutput("collide_l2", {31'b0, rv2}, 0);
      expectLoad("collide_store", 32'h4, MEM_WORD, 1'b0, 32'hA5A5A5A5);
      applyStimulus(1'b0, 1'b1, MEM_HALF, 1'b0, 32'h6, 32'h0000BEEF);
      expectLoad("half_signed", 32'h6, MEM_HALF, 1'b0, 32'hFFFFBEEF);
      expectLoad("half_word", 32'h4, MEM_WORD, 1'b0, 32'hBEEFA5A5);

      $display("[TB] back-to-back loads");
      applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0, '0);
      checkOutput("b2b_l2_first_idle", {31'b0, rv2}, 0);
      applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h4, '0);
      checkOutput("b2b_l2_p1", rd2, 32'hCAFEF00D);
      applyStimulus(1'b1, 1'b0, MEM_HALF, 1'b1, 32'h6, '0);
      checkOutput("b2b_l2_p2", rd2, 32'hBEEFA5A5);
      idle();
      tick();
      checkOutput("b2b_l2_p3_valid", {31'b0, rv2}, 1);
      checkOutput("b2b_l2_p3", rd2, 32'h0000BEEF);
      tick();
      checkOutput("b2b_l2_end", {31'b0, rv2}, 0);
      checkOutput("b2b_l2_hold", rd2, 32'h0000BEEF);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0, '0);
      applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h4, '0);
      applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h8, '0);
      rst = 1'b1;
      #1;
      checkOutput("rst_now_l2_valid", {31'b0, rv2}, 0);
      checkOutput("rst_now_l2_data", rd2, 0);
      checkOutput("rst_now_l1_data", rd1, 0);
      mem_read = 1'b0;
      mem_write = 1'b1; mem_size = MEM_WORD; addr = 32'h0; write_data = 32'hFFFFFFFF;
      tick(); tick();
      idle();
      rst = 1'b0;
      tick(); tick();
      expectLoad("rst_keeps_mem", 32'h0, MEM_WORD, 1'b0, 32'hCAFEF00D);

      $display("[TB] random transactions");
      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 9);
         rs = (sel < 3) ? MEM_BYTE : (sel < 6) ? MEM_HALF : (sel < 9) ? MEM_WORD : MEM_RSVD;
         ra = 32'($urandom_range(0, 2 * BYTE_SPACE - 1));
         if ($urandom_range(0, 4) != 0) begin
            if (rs == MEM_HALF) ra[0] = 1'b0;
            if (rs == MEM_WORD) ra[1:0] = 2'b00;
         end
         sel = $urandom_range(0, 9);
         if (sel < 4)      applyStimulus(1'b0, 1'b1, rs, 1'($urandom_range(0, 1)), ra, $urandom);
         else if (sel < 8) applyStimulus(1'b1, 1'b0, rs, 1'($urandom_range(0, 1)), ra, $urandom);
         else if (sel < 9) applyStimulus(1'b1, 1'b1, rs, 1'($urandom_range(0, 1)), ra, $urandom);
         else begin
            idle();
            tick();
         end
      end
      idle();
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
